// File: rtl/reg_file_32x32.sv
// reg_file_32x32: 32 x DATA_W MIPS general-purpose register file.
// Two combinational read ports and one synchronous write port. A 32-bit
// counter tracks committed writes, meaning writes that actually change
// storage.
// Optional build macro REGFILE_BYPASS_EN adds a write-through bypass on each
// read port. With the macro undefined, a same-cycle read returns the old
// stored value.
// Register 0 always reads as zero. Writes to register 0 are dropped and are
// not counted.

module reg_file_32x32 #(
  parameter int               DATA_W  = 32,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_3FFC,
  parameter logic [DATA_W-1:0] GP_INIT = 32'h0000_1800
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [4:0]        ReadReg1,
  input  logic [4:0]        ReadReg2,
  input  logic [4:0]        WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [31:0]       WriteCount
);

  logic [DATA_W-1:0] r_regs [0:31];
  logic [31:0]       r_write_count;

  // A write commits only when enabled and not aimed at register 0.
  // Reset still wins at the clock edge.
  logic w_write_en;
  assign w_write_en = RegWrite && (WriteReg != 5'd0);

  // Storage update: reset loads $gp/$sp and zeroes everything else. Otherwise
  // a qualified write updates one entry.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
      r_regs[28] <= GP_INIT;
      r_regs[29] <= SP_INIT;
    end else if (w_write_en) begin
      r_regs[WriteReg] <= WriteData;
    end
  end

  // Committed-write counter. It wraps silently modulo 2^32.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_write_count <= 32'd0;
    end else if (w_write_en) begin
      r_write_count <= r_write_count + 32'd1;
    end
  end

  assign WriteCount = r_write_count;

`ifdef REGFILE_BYPASS_EN
  // Bypass qualifier per port. Reset suppresses forwarding, and register 0
  // never forwards because w_write_en already excludes it.
  logic w_bypass1;
  logic w_bypass2;
  assign w_bypass1 = w_write_en && !Reset && (ReadReg1 == WriteReg);
  assign w_bypass2 = w_write_en && !Reset && (ReadReg2 == WriteReg);

  // Read ports with write-through forwarding. Register 0 is forced to zero.
  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (ReadReg1 != 5'd0) begin
      ReadData1 = w_bypass1 ? WriteData : r_regs[ReadReg1];
    end
    if (ReadReg2 != 5'd0) begin
      ReadData2 = w_bypass2 ? WriteData : r_regs[ReadReg2];
    end
  end
`else
  // Read ports straight from storage. Register 0 is forced to zero. A
  // same-cycle write becomes visible only after the edge.
  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (ReadReg1 != 5'd0) begin
      ReadData1 = r_regs[ReadReg1];
    end
    if (ReadReg2 != 5'd0) begin
      ReadData2 = r_regs[ReadReg2];
    end
  end
`endif

endmodule

// File: tb/tb_reg_file_32x32.sv
// Directed testbench for reg_file_32x32. All expected values are hand-computed
// constants. Build with +define+REGFILE_BYPASS_EN to check the bypass variant.

module tb_reg_file_32x32;

  logic        Clk;
  logic        Reset;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] WriteCount;

  int n_checks = 0;
  int n_errors = 0;

  reg_file_32x32 dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .ReadReg1   (ReadReg1),
    .ReadReg2   (ReadReg2),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .RegWrite   (RegWrite),
    .ReadData1  (ReadData1),
    .ReadData2  (ReadData2),
    .WriteCount (WriteCount)
  );

  // Clock generation
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single comparison point for every check in the bench
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge and land 1ns after it
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Set up a write for the next edge
  task automatic drive_write(input logic [4:0] addr, input logic [31:0] data);
    RegWrite  = 1'b1;
    WriteReg  = addr;
    WriteData = data;
  endtask

  task automatic idle_write();
    RegWrite  = 1'b0;
    WriteReg  = 5'd0;
    WriteData = 32'd0;
  endtask

  logic [31:0] exp_val;

  initial begin
    Reset    = 1'b1;
    ReadReg1 = 5'd0;
    ReadReg2 = 5'd0;
    idle_write();

    // Reset: hold for one edge, then sweep every address on both ports
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i);
      ReadReg2 = 5'(31 - i);
      #1;
      exp_val = (i == 28) ? 32'h0000_1800 : (i == 29) ? 32'h0000_3FFC : 32'd0;
      check_eq($sformatf("reset_rd1[%0d]", i), ReadData1, exp_val);
      exp_val = ((31 - i) == 28) ? 32'h0000_1800 : ((31 - i) == 29) ? 32'h0000_3FFC : 32'd0;
      check_eq($sformatf("reset_rd2[%0d]", 31 - i), ReadData2, exp_val);
    end
    check_eq("reset_count", WriteCount, 32'd0);

    // Write/readback, including the jal link register
    drive_write(5'd5, 32'hDEAD_BEEF);
    tick();
    drive_write(5'd31, 32'h1234_5678);
    tick();
    idle_write();
    ReadReg1 = 5'd5;
    ReadReg2 = 5'd31;
    #1;
    check_eq("wr_rd1_reg5", ReadData1, 32'hDEAD_BEEF);
    check_eq("wr_rd2_reg31", ReadData2, 32'h1234_5678);
    check_eq("wr_count2", WriteCount, 32'd2);

    // Register 0: the write is discarded and not counted
    drive_write(5'd0, 32'hFFFF_FFFF);
    ReadReg1 = 5'd0;
    ReadReg2 = 5'd0;
    #1;
    check_eq("zero_same_cycle", ReadData1, 32'd0);
    tick();
    idle_write();
    #1;
    check_eq("zero_rd1", ReadData1, 32'd0);
    check_eq("zero_rd2", ReadData2, 32'd0);
    check_eq("zero_count", WriteCount, 32'd2);

    // Same-cycle read-after-write on reg 7
    drive_write(5'd7, 32'h0000_0011);
    tick();
    drive_write(5'd7, 32'h0000_0022);
    ReadReg1 = 5'd7;
    ReadReg2 = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    check_eq("raw_same_rd1", ReadData1, 32'h0000_0022);
    check_eq("raw_same_rd2", ReadData2, 32'h0000_0022);
`else
    check_eq("raw_same_rd1", ReadData1, 32'h0000_0011);
    check_eq("raw_same_rd2", ReadData2, 32'h0000_0011);
`endif
    tick();
    idle_write();
    #1;
    check_eq("raw_next_rd1", ReadData1, 32'h0000_0022);
    check_eq("raw_next_rd2", ReadData2, 32'h0000_0022);
    check_eq("raw_count", WriteCount, 32'd4);

    // RegWrite=0: storage and counter hold even with an address and data present
    RegWrite  = 1'b0;
    WriteReg  = 5'd5;
    WriteData = 32'h0BAD_0BAD;
    ReadReg1  = 5'd5;
    tick();
    #1;
    check_eq("hold_reg5", ReadData1, 32'hDEAD_BEEF);
    check_eq("hold_count", WriteCount, 32'd4);

    // Reset collides with a write to $sp: reset wins and the write is not counted
    drive_write(5'd29, 32'hAAAA_AAAA);
    Reset    = 1'b1;
    ReadReg1 = 5'd5;
    ReadReg2 = 5'd29;
    #1;
    check_eq("prereset_reg5", ReadData1, 32'hDEAD_BEEF);
    check_eq("prereset_reg29", ReadData2, 32'h0000_3FFC);
    tick();
    Reset = 1'b0;
    idle_write();
    #1;
    check_eq("coll_reg5", ReadData1, 32'd0);
    check_eq("coll_reg29", ReadData2, 32'h0000_3FFC);
    check_eq("coll_count", WriteCount, 32'd0);

    // Counter wrap: deposit all-ones, then make one valid write
    force dut.r_write_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_write_count;
    drive_write(5'd3, 32'h0000_0055);
    ReadReg1 = 5'd3;
    tick();
    idle_write();
    #1;
    check_eq("wrap_count", WriteCount, 32'd0);
    check_eq("wrap_reg3", ReadData1, 32'h0000_0055);
    drive_write(5'd4, 32'h0000_0066);
    ReadReg2 = 5'd4;
    tick();
    idle_write();
    #1;
    check_eq("post_wrap_count", WriteCount, 32'd1);
    check_eq("post_wrap_reg4", ReadData2, 32'h0000_0066);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
